// File: rtl/uart_rx_hamming_ctrl_pkg.sv
// rtl/uart_rx_hamming_ctrl_pkg.sv - shared widths, timeout, FSM state type and Hamming syndrome helper
package uart_rx_hamming_ctrl_pkg;

  localparam int UART_DATA_WIDTH                   = 8;
  localparam int UART_RX_HAMMING_DECODER_EDC_WIDTH = 4;
  localparam int UART_RX_EDC_TIMEOUT               = 1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_EDC,
    ST_DECODE,
    ST_HOLD
  } state_t;

  // Bit i of the result is syndrome bit s_i; a flipped data bit maps to a unique non-power-of-two value.
  function automatic logic [3:0] calc_syndrome(input logic [7:0] d, input logic [3:0] e);
    logic [3:0] s;
    s[0] = e[3] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    s[1] = e[2] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    s[2] = e[1] ^ d[6] ^ d[5] ^ d[4] ^ d[0];
    s[3] = e[0] ^ d[3] ^ d[2] ^ d[1] ^ d[0];
    return s;
  endfunction

endpackage

// File: rtl/uart_rx_hamming_ctrl_hamdec.sv
// rtl/uart_rx_hamming_ctrl_hamdec.sv - combinational Hamming corrector for one data byte and its EDC nibble
module uart_rx_hamming_ctrl_hamdec
  import uart_rx_hamming_ctrl_pkg::*;
(
  input  logic [7:0] data_in,
  input  logic [3:0] edc_in,
  output logic [7:0] data_out
);

  logic [3:0] syn;

  assign syn = calc_syndrome(data_in, edc_in);

  // EDC-bit syndromes and 0xD-0xF leave the data untouched.
  always_comb begin
    data_out = data_in;
    case (syn)
      4'h3:    data_out[7] = ~data_in[7];
      4'h5:    data_out[6] = ~data_in[6];
      4'h6:    data_out[5] = ~data_in[5];
      4'h7:    data_out[4] = ~data_in[4];
      4'h9:    data_out[3] = ~data_in[3];
      4'hA:    data_out[2] = ~data_in[2];
      4'hB:    data_out[1] = ~data_in[1];
      4'hC:    data_out[0] = ~data_in[0];
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/uart_rx_hamming_ctrl.sv
// rtl/uart_rx_hamming_ctrl.sv - pairs data/EDC bytes from UART RX, corrects them and holds the result behind valid/ready
module uart_rx_hamming_ctrl
  import uart_rx_hamming_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = UART_DATA_WIDTH,
  parameter int EDC_WIDTH      = UART_RX_HAMMING_DECODER_EDC_WIDTH,
  parameter int TIMEOUT_CYCLES = UART_RX_EDC_TIMEOUT,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  err_corrected,
  output logic                  err_uncorrected,
  output logic                  timeout,
  output logic                  overrun,
  input  logic                  stat_clear,
  output logic [CNT_WIDTH-1:0]  cnt_corrected,
  output logic [CNT_WIDTH-1:0]  cnt_uncorrected,
  output logic [CNT_WIDTH-1:0]  cnt_timeout
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [EDC_WIDTH-1:0]  edc_q, edc_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  err_corr_q, err_corr_d;
  logic                  err_unc_q, err_unc_d;
  logic                  timeout_q, timeout_d;
  logic                  overrun_q, overrun_d;
  logic [CNT_WIDTH-1:0]  cnt_corr_q, cnt_corr_d;
  logic [CNT_WIDTH-1:0]  cnt_unc_q, cnt_unc_d;
  logic [CNT_WIDTH-1:0]  cnt_to_q, cnt_to_d;

  logic [DATA_WIDTH-1:0] corr_data;
  logic [3:0]            syndrome;
  logic                  corr_flag;
  logic                  unc_flag;

  uart_rx_hamming_ctrl_hamdec u_hamdec (
    .data_in  (data_q),
    .edc_in   (edc_q),
    .data_out (corr_data)
  );

  // Local syndrome: the corrector gives no trustworthy error flag for 0xD-0xF.
  assign syndrome  = calc_syndrome(data_q, edc_q);
  assign corr_flag = (corr_data != data_q);
  assign unc_flag  = (syndrome != 4'h0) && !corr_flag;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    edc_d        = edc_q;
    tmr_d        = tmr_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    err_corr_d   = err_corr_q;
    err_unc_d    = err_unc_q;
    timeout_d    = 1'b0;
    overrun_d    = overrun_q;
    cnt_corr_d   = cnt_corr_q;
    cnt_unc_d    = cnt_unc_q;
    cnt_to_d     = cnt_to_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          data_d  = rx_data;
          tmr_d   = '0;
          state_d = ST_WAIT_EDC;
        end
      end
      ST_WAIT_EDC: begin
        // A byte on the expiry cycle still counts as the EDC byte.
        if (rx_valid) begin
          edc_d   = rx_data[EDC_WIDTH-1:0];
          state_d = ST_DECODE;
        end else if (tmr_q == TMR_LAST) begin
          timeout_d = 1'b1;
          cnt_to_d  = sat_inc(cnt_to_q);
          data_d    = '0;
          state_d   = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_DECODE: begin
        dout_d       = corr_data;
        err_corr_d   = corr_flag;
        err_unc_d    = unc_flag;
        dout_valid_d = 1'b1;
        if (corr_flag) cnt_corr_d = sat_inc(cnt_corr_q);
        if (unc_flag)  cnt_unc_d  = sat_inc(cnt_unc_q);
        state_d      = ST_HOLD;
      end
      ST_HOLD: begin
        if (rx_valid) overrun_d = 1'b1;
        if (dout_valid_q && dout_ready) begin
          dout_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (stat_clear) begin
      cnt_corr_d = '0;
      cnt_unc_d  = '0;
      cnt_to_d   = '0;
      overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      edc_q        <= '0;
      tmr_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      err_corr_q   <= 1'b0;
      err_unc_q    <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
      cnt_corr_q   <= '0;
      cnt_unc_q    <= '0;
      cnt_to_q     <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      edc_q        <= edc_d;
      tmr_q        <= tmr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      err_corr_q   <= err_corr_d;
      err_unc_q    <= err_unc_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
      cnt_corr_q   <= cnt_corr_d;
      cnt_unc_q    <= cnt_unc_d;
      cnt_to_q     <= cnt_to_d;
    end
  end

  assign dout            = dout_q;
  assign dout_valid      = dout_valid_q;
  assign err_corrected   = err_corr_q;
  assign err_uncorrected = err_unc_q;
  assign timeout         = timeout_q;
  assign overrun         = overrun_q;
  assign cnt_corrected   = cnt_corr_q;
  assign cnt_uncorrected = cnt_unc_q;
  assign cnt_timeout     = cnt_to_q;

endmodule

// File: tb/tb_uart_rx_hamming_ctrl.sv
// tb/tb_uart_rx_hamming_ctrl.sv - bench for uart_rx_hamming_ctrl against a transaction-level model
module tb_uart_rx_hamming_ctrl;

  localparam int TO   = 1000;
  localparam int CMAX = 255;

  localparam int EV_INC_C = 0;
  localparam int EV_INC_U = 1;
  localparam int EV_INC_T = 2;
  localparam int EV_OVR   = 3;
  localparam int EV_CLR   = 4;

  localparam int S_DOUT = 0, S_VALID = 1, S_EC = 2, S_EU = 3, S_TO = 4;
  localparam int S_OVR = 5, S_CC = 6, S_CU = 7, S_CT = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       dout_ready = 1'b0;
  logic       stat_clear = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       err_corrected;
  logic       err_uncorrected;
  logic       timeout;
  logic       overrun;
  logic [7:0] cnt_corrected;
  logic [7:0] cnt_uncorrected;
  logic [7:0] cnt_timeout;

  uart_rx_hamming_ctrl #(
    .DATA_WIDTH     (8),
    .EDC_WIDTH      (4),
    .TIMEOUT_CYCLES (TO),
    .CNT_WIDTH      (8)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .dout            (dout),
    .dout_valid      (dout_valid),
    .dout_ready      (dout_ready),
    .err_corrected   (err_corrected),
    .err_uncorrected (err_uncorrected),
    .timeout         (timeout),
    .overrun         (overrun),
    .stat_clear      (stat_clear),
    .cnt_corrected   (cnt_corrected),
    .cnt_uncorrected (cnt_uncorrected),
    .cnt_timeout     (cnt_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; int k;} ev_t;
  typedef struct {int c; int sig; int v;} lit_t;
  typedef struct {int sig; int off; int v;} stg_t;

  ev_t  evq[$];
  lit_t litq[$];
  stg_t stgq[$];

  int         n_cmp = 0;
  int         n_fail = 0;
  int         win_lo = -100;
  int         win_hi = -200;
  int         to_cyc = -1;
  logic [7:0] x_dout = 8'h00;
  logic       x_ec = 1'b0;
  logic       x_eu = 1'b0;
  bit         chk_en = 1'b0;
  bit         noise = 1'b0;
  int         m_cc = 0;
  int         m_cu = 0;
  int         m_ct = 0;
  bit         m_ovr = 1'b0;

  logic [7:0] r_d;
  logic [7:0] r_e;
  logic [3:0] r_s;
  int         r_sel;
  int         n_rand_to = 0;

  function automatic logic [3:0] m_syn(input logic [7:0] d, input logic [3:0] e);
    logic [3:0] s;
    s[0] = e[3] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    s[1] = e[2] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    s[2] = e[1] ^ d[6] ^ d[5] ^ d[4] ^ d[0];
    s[3] = e[0] ^ d[3] ^ d[2] ^ d[1] ^ d[0];
    return s;
  endfunction

  // The corrected word is the single-data-bit neighbour whose syndrome vanishes, if any.
  function automatic logic [7:0] m_fix(input logic [7:0] d, input logic [3:0] e);
    logic [7:0] f;
    if (m_syn(d, e) == 4'h0) return d;
    for (int i = 0; i < 8; i++) begin
      f = d ^ (8'h01 << i);
      if (m_syn(f, e) == 4'h0) return f;
    end
    return d;
  endfunction

  function automatic logic [31:0] sig_val(input int sig);
    case (sig)
      S_DOUT:  return 32'(dout);
      S_VALID: return 32'(dout_valid);
      S_EC:    return 32'(err_corrected);
      S_EU:    return 32'(err_uncorrected);
      S_TO:    return 32'(timeout);
      S_OVR:   return 32'(overrun);
      S_CC:    return 32'(cnt_corrected);
      S_CU:    return 32'(cnt_uncorrected);
      S_CT:    return 32'(cnt_timeout);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : cmp
    bit clr;
    bit exp_v;
    clr = 1'b0;
    foreach (evq[i]) begin
      if (evq[i].c == cyc) begin
        case (evq[i].k)
          EV_INC_C: if (m_cc < CMAX) m_cc++;
          EV_INC_U: if (m_cu < CMAX) m_cu++;
          EV_INC_T: if (m_ct < CMAX) m_ct++;
          EV_OVR:   m_ovr = 1'b1;
          default:  clr = 1'b1;
        endcase
      end
    end
    if (clr) begin
      m_cc  = 0;
      m_cu  = 0;
      m_ct  = 0;
      m_ovr = 1'b0;
    end
    evq = evq.find with (item.c > cyc);
    if (chk_en) begin
      exp_v = (cyc >= win_lo) && (cyc <= win_hi);
      chk("dout_valid", 32'(dout_valid), 32'(exp_v));
      if (exp_v) begin
        chk("dout", 32'(dout), 32'(x_dout));
        chk("err_corrected", 32'(err_corrected), 32'(x_ec));
        chk("err_uncorrected", 32'(err_uncorrected), 32'(x_eu));
      end
      chk("timeout", 32'(timeout), 32'(cyc == to_cyc));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("cnt_corrected", 32'(cnt_corrected), 32'(m_cc));
      chk("cnt_uncorrected", 32'(cnt_uncorrected), 32'(m_cu));
      chk("cnt_timeout", 32'(cnt_timeout), 32'(m_ct));
    end
    foreach (litq[i]) begin
      if (litq[i].c == cyc)
        chk($sformatf("literal_sig%0d", litq[i].sig), sig_val(litq[i].sig), 32'(litq[i].v));
    end
    litq = litq.find with (item.c > cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rx_valid   = 1'b0;
    stat_clear = 1'b0;
    rx_data    = 8'($urandom);
    dout_ready = noise ? 1'($urandom) : 1'b0;
    if (noise && $urandom_range(0, 24) == 0) begin
      stat_clear = 1'b1;
      evq.push_back('{cyc + 1, EV_CLR});
    end
  endtask

  task automatic stage(input int sig, input int off, input int v);
    stgq.push_back('{sig, off, v});
  endtask

  task automatic all_zero_lits_now();
    for (int s = S_DOUT; s <= S_CT; s++) litq.push_back('{cyc, s, 0});
  endtask

  // gap: idle cycles between data and EDC; hold: cycles dout_ready stays low; inj: offset from the EDC strobe for a stray byte.
  task automatic send_pair(input logic [7:0] d, input logic [7:0] eb, input int gap, input int hold, input int inj);
    int m;
    int k;
    logic [7:0] fx;
    logic [3:0] s;
    tick();
    rx_valid = 1'b1;
    rx_data  = d;
    repeat (gap) tick();
    tick();
    rx_valid = 1'b1;
    rx_data  = eb;
    m  = cyc;
    k  = m + 2 + hold;
    s  = m_syn(d, eb[3:0]);
    fx = m_fix(d, eb[3:0]);
    x_dout = fx;
    x_ec   = (fx != d);
    x_eu   = (s != 4'h0) && (fx == d);
    win_lo = m + 2;
    win_hi = k;
    if (x_ec) evq.push_back('{m + 2, EV_INC_C});
    if (x_eu) evq.push_back('{m + 2, EV_INC_U});
    foreach (stgq[i]) litq.push_back('{m + 2 + stgq[i].off, stgq[i].sig, stgq[i].v});
    stgq.delete();
    for (int c = m + 1; c <= k; c++) begin
      tick();
      if (c >= m + 2) dout_ready = (c == k);
      if (c == m + inj || (noise && $urandom_range(0, 7) == 0)) begin
        rx_valid = 1'b1;
        if (c == m + inj) rx_data = 8'h12;
        if (c >= m + 2) evq.push_back('{c + 1, EV_OVR});
      end
    end
  endtask

  task automatic timeout_case(input logic [7:0] d);
    int t;
    tick();
    rx_valid = 1'b1;
    rx_data  = d;
    t = cyc;
    to_cyc = t + TO + 1;
    evq.push_back('{t + TO + 1, EV_INC_T});
    foreach (stgq[i]) litq.push_back('{t + TO + 1 + stgq[i].off, stgq[i].sig, stgq[i].v});
    stgq.delete();
    repeat (TO) tick();
  endtask

  initial begin
    reset_n = 1'b0;
    tick();
    all_zero_lits_now();
    tick();
    reset_n = 1'b1;
    tick();
    chk_en = 1'b1;

    stage(S_DOUT, 0, 8'hFF); stage(S_EC, 0, 0); stage(S_EU, 0, 0);
    stage(S_CC, 0, 0); stage(S_CU, 0, 0); stage(S_VALID, 0, 1);
    send_pair(8'hFF, 8'h0C, 0, 0, -1);

    stage(S_DOUT, 0, 8'h00); stage(S_EC, 0, 1); stage(S_EU, 0, 0); stage(S_CC, 0, 1);
    send_pair(8'h80, 8'h00, 1, 2, -1);

    stage(S_DOUT, 0, 8'h00); stage(S_EU, 0, 1); stage(S_EC, 0, 0); stage(S_CU, 0, 1);
    send_pair(8'h00, 8'h08, 0, 0, -1);
    stage(S_DOUT, 0, 8'h00); stage(S_EU, 0, 1); stage(S_CU, 0, 2);
    send_pair(8'h00, 8'h0F, 2, 1, -1);

    stage(S_TO, 0, 1); stage(S_TO, 1, 0); stage(S_CT, 0, 1); stage(S_VALID, 0, 0);
    timeout_case(8'h55);
    stage(S_VALID, 0, 1); stage(S_DOUT, 0, 8'hFF); stage(S_CT, 0, 1); stage(S_TO, 0, 0);
    send_pair(8'hFF, 8'h0C, TO - 1, 0, -1);

    stage(S_OVR, 8, 0); stage(S_OVR, 9, 1); stage(S_DOUT, 50, 8'h3C); stage(S_VALID, 50, 1);
    send_pair(8'h3C, 8'h04, 0, 50, 10);
    stage(S_DOUT, 0, 8'hFF); stage(S_EC, 0, 0); stage(S_OVR, 0, 1);
    send_pair(8'hFF, 8'h0C, 0, 0, -1);
    tick();
    stat_clear = 1'b1;
    evq.push_back('{cyc + 1, EV_CLR});
    litq.push_back('{cyc + 1, S_OVR, 0});
    litq.push_back('{cyc + 1, S_CC, 0});
    litq.push_back('{cyc + 1, S_CT, 0});

    for (int i = 0; i < 300; i++) begin
      if (i == 254) stage(S_CC, 0, 255);
      if (i == 299) stage(S_CC, 0, 255);
      send_pair(8'h80, 8'h00, 0, 0, -1);
    end

    tick();
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    tick();
    reset_n = 1'b0;
    chk_en  = 1'b0;
    evq.push_back('{cyc, EV_CLR});
    all_zero_lits_now();
    tick();
    reset_n = 1'b1;
    tick();
    chk_en = 1'b1;
    stage(S_DOUT, 0, 8'hFF); stage(S_EC, 0, 0); stage(S_EU, 0, 0); stage(S_CC, 0, 0);
    send_pair(8'hFF, 8'h0C, 0, 0, -1);

    noise = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if (n_rand_to < 2 && $urandom_range(0, 49) == 0) begin
        n_rand_to++;
        timeout_case(8'($urandom));
      end else begin
        r_d = 8'($urandom);
        r_s = m_syn(r_d, 4'h0);
        r_e = {4'($urandom), r_s[0], r_s[1], r_s[2], r_s[3]};
        r_sel = $urandom_range(0, 3);
        if (r_sel == 1) r_d = r_d ^ (8'h01 << $urandom_range(0, 7));
        if (r_sel == 2) r_e = r_e ^ (8'h01 << $urandom_range(0, 3));
        if (r_sel == 3) r_e = 8'($urandom);
        send_pair(r_d, r_e, $urandom_range(0, 3), $urandom_range(0, 4),
                  ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(1, 4));
      end
    end
    noise = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
